// File: rtl/ofs_avmm_split_pkg.sv
// Shared types and helpers for the AVMM burst splitter.
package ofs_avmm_split_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } split_state_t;

    function automatic int unsigned be_w(input int unsigned data_w, input int unsigned symb_w);
        return data_w / symb_w;
    endfunction

endpackage

// File: rtl/ofs_avmm_split_len_fifo.sv
// Small synchronous FIFO holding the beat count of each outstanding write burst.
module ofs_avmm_split_len_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ofs_avmm_burst_splitter.sv
// Splits upstream AVMM bursts into single-beat downstream transfers and folds
// per-beat write responses back into one response per burst.
module ofs_avmm_burst_splitter
    import ofs_avmm_split_pkg::*;
#(
    parameter  int unsigned DATA_W      = 64,
    parameter  int unsigned ADDR_W      = 16,
    parameter  int unsigned BURST_W     = 4,
    parameter  int unsigned SYMB_W      = 8,
    parameter  int unsigned WRRSP_DEPTH = 4,
    localparam int unsigned BE_W        = be_w(DATA_W, SYMB_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_write,
    input  logic               s_read,
    input  logic [ADDR_W-1:0]  s_address,
    input  logic [DATA_W-1:0]  s_writedata,
    input  logic [BE_W-1:0]    s_byteenable,
    input  logic [BURST_W-1:0] s_burstcount,
    output logic               s_waitrequest,
    output logic               s_readdatavalid,
    output logic [DATA_W-1:0]  s_readdata,
    output logic               s_writeresponsevalid,
    output logic               m_write,
    output logic               m_read,
    output logic [ADDR_W-1:0]  m_address,
    output logic [DATA_W-1:0]  m_writedata,
    output logic [BE_W-1:0]    m_byteenable,
    output logic               m_burstcount,
    input  logic               m_waitrequest,
    input  logic               m_readdatavalid,
    input  logic [DATA_W-1:0]  m_readdata,
    input  logic               m_writeresponsevalid
);

    split_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [BURST_W-1:0] remain_q, remain_d;
    logic [BURST_W-1:0] rsp_cnt_q, rsp_cnt_d;
    logic               wrrsp_valid_q;
    logic [BURST_W-1:0] len_c;
    logic               fifo_push_c;
    logic               fifo_pop_c;
    logic               fifo_full;
    logic               fifo_empty;
    logic [BURST_W-1:0] fifo_head;

    assign m_writedata     = s_writedata;
    assign m_byteenable    = s_byteenable;
    assign m_burstcount    = 1'b1;
    assign s_readdatavalid = m_readdatavalid;
    assign s_readdata      = m_readdata;
    assign s_writeresponsevalid = wrrsp_valid_q;

    assign len_c = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;

    ofs_avmm_split_len_fifo #(
        .DEPTH (WRRSP_DEPTH),
        .WIDTH (BURST_W)
    ) u_len_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push_c),
        .din_i   (len_c),
        .pop_i   (fifo_pop_c),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Command FSM: next state, downstream strobes and upstream backpressure
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        remain_d      = remain_q;
        m_write       = 1'b0;
        m_read        = 1'b0;
        m_address     = base_q;
        s_waitrequest = 1'b1;
        fifo_push_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_write) begin
                    // A full response FIFO must also hold off the downstream write.
                    m_write       = !fifo_full;
                    m_address     = s_address;
                    s_waitrequest = m_waitrequest || fifo_full;
                    if (!s_waitrequest) begin
                        fifo_push_c = 1'b1;
                        base_d      = ADDR_W'(s_address + ADDR_W'(1));
                        remain_d    = BURST_W'(len_c - BURST_W'(1));
                        if (len_c > BURST_W'(1)) state_d = WR_BURST;
                    end
                end else if (s_read) begin
                    m_read        = 1'b1;
                    m_address     = s_address;
                    s_waitrequest = m_waitrequest;
                    if (!m_waitrequest) begin
                        base_d   = ADDR_W'(s_address + ADDR_W'(1));
                        remain_d = BURST_W'(len_c - BURST_W'(1));
                        if (len_c > BURST_W'(1)) state_d = RD_BURST;
                    end
                end
            end
            WR_BURST: begin
                m_write       = s_write;
                s_waitrequest = m_waitrequest;
                if (s_write && !m_waitrequest) begin
                    base_d   = ADDR_W'(base_q + ADDR_W'(1));
                    remain_d = BURST_W'(remain_q - BURST_W'(1));
                    if (remain_q == BURST_W'(1)) state_d = IDLE;
                end
            end
            RD_BURST: begin
                m_read = 1'b1;
                if (!m_waitrequest) begin
                    base_d   = ADDR_W'(base_q + ADDR_W'(1));
                    remain_d = BURST_W'(remain_q - BURST_W'(1));
                    if (remain_q == BURST_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            m_write       = 1'b0;
            m_read        = 1'b0;
            s_waitrequest = 1'b1;
            fifo_push_c   = 1'b0;
        end
    end

    // Response folding: count downstream responses against the head burst length
    always_comb begin
        fifo_pop_c = m_writeresponsevalid && !fifo_empty
                     && (BURST_W'(rsp_cnt_q + BURST_W'(1)) == fifo_head);
        rsp_cnt_d  = rsp_cnt_q;
        if (fifo_pop_c) begin
            rsp_cnt_d = '0;
        end else if (m_writeresponsevalid && !fifo_empty) begin
            rsp_cnt_d = BURST_W'(rsp_cnt_q + BURST_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= '0;
            remain_q      <= '0;
            rsp_cnt_q     <= '0;
            wrrsp_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            remain_q      <= remain_d;
            rsp_cnt_q     <= rsp_cnt_d;
            wrrsp_valid_q <= fifo_pop_c;
        end
    end

endmodule

// File: tb/tb_ofs_avmm_burst_splitter.sv
// Directed self-checking bench for ofs_avmm_burst_splitter.
module tb_ofs_avmm_burst_splitter;

    logic        clk;
    logic        rst;
    logic        s_write;
    logic        s_read;
    logic [15:0] s_address;
    logic [63:0] s_writedata;
    logic [7:0]  s_byteenable;
    logic [3:0]  s_burstcount;
    logic        s_waitrequest;
    logic        s_readdatavalid;
    logic [63:0] s_readdata;
    logic        s_writeresponsevalid;
    logic        m_write;
    logic        m_read;
    logic [15:0] m_address;
    logic [63:0] m_writedata;
    logic [7:0]  m_byteenable;
    logic        m_burstcount;
    logic        m_waitrequest;
    logic        m_readdatavalid;
    logic [63:0] m_readdata;
    logic        m_writeresponsevalid;

    int n_cmp;
    int n_bad;
    int n_wrrsp;
    int n0;

    ofs_avmm_burst_splitter dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_write              (s_write),
        .s_read               (s_read),
        .s_address            (s_address),
        .s_writedata          (s_writedata),
        .s_byteenable         (s_byteenable),
        .s_burstcount         (s_burstcount),
        .s_waitrequest        (s_waitrequest),
        .s_readdatavalid      (s_readdatavalid),
        .s_readdata           (s_readdata),
        .s_writeresponsevalid (s_writeresponsevalid),
        .m_write              (m_write),
        .m_read               (m_read),
        .m_address            (m_address),
        .m_writedata          (m_writedata),
        .m_byteenable         (m_byteenable),
        .m_burstcount         (m_burstcount),
        .m_waitrequest        (m_waitrequest),
        .m_readdatavalid      (m_readdatavalid),
        .m_readdata           (m_readdata),
        .m_writeresponsevalid (m_writeresponsevalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_writeresponsevalid) n_wrrsp <= n_wrrsp + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_wrrsp = 0;
        rst = 1'b1;
        s_write = 1'b1; s_read = 1'b0; s_address = 16'h0; s_writedata = '0;
        s_byteenable = 8'hFF; s_burstcount = 4'd1;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
        m_writeresponsevalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_m_write", 64'(m_write), 64'd0);
        check_val("rst_m_read", 64'(m_read), 64'd0);
        check_val("rst_s_wait", 64'(s_waitrequest), 64'd1);
        check_val("rst_s_wrrsp", 64'(s_writeresponsevalid), 64'd0);
        check_val("burstcount_tie", 64'(m_burstcount), 64'd1);
        s_write = 1'b0;
        rst = 1'b0;
        tick();

        // 1: write burst 4 @0x0010
        for (int i = 0; i < 4; i++) begin
            s_write = 1'b1;
            s_address = (i == 0) ? 16'h0010 : 16'hDEAD;
            s_burstcount = (i == 0) ? 4'd4 : 4'd9;
            s_writedata = 64'hA0 + 64'(i);
            s_byteenable = 8'h0F << i;
            settle();
            check_val("t1_m_write", 64'(m_write), 64'd1);
            check_val("t1_addr", 64'(m_address), 64'h10 + 64'(i));
            check_val("t1_wait", 64'(s_waitrequest), 64'd0);
            check_val("t1_wdata", m_writedata, 64'hA0 + 64'(i));
            check_val("t1_be", 64'(m_byteenable), 64'(8'h0F << i));
            tick();
        end
        s_write = 1'b0;
        settle();
        check_val("t1_idle_m_write", 64'(m_write), 64'd0);
        for (int i = 0; i < 4; i++) begin
            m_writeresponsevalid = 1'b1;
            tick();
            check_val("t1_wrrsp", 64'(s_writeresponsevalid), (i == 3) ? 64'd1 : 64'd0);
        end
        m_writeresponsevalid = 1'b0;
        tick();
        check_val("t1_wrrsp_pulse", 64'(s_writeresponsevalid), 64'd0);

        // 2: read burst 3 @0x0100 with downstream stall on cycle 2
        s_read = 1'b1; s_address = 16'h0100; s_burstcount = 4'd3;
        settle();
        check_val("t2_m_read0", 64'(m_read), 64'd1);
        check_val("t2_addr0", 64'(m_address), 64'h100);
        check_val("t2_wait0", 64'(s_waitrequest), 64'd0);
        tick();
        s_read = 1'b0; m_waitrequest = 1'b1;
        settle();
        check_val("t2_m_read1", 64'(m_read), 64'd1);
        check_val("t2_addr1", 64'(m_address), 64'h101);
        check_val("t2_wait1", 64'(s_waitrequest), 64'd1);
        tick();
        m_waitrequest = 1'b0;
        settle();
        check_val("t2_addr1_held", 64'(m_address), 64'h101);
        tick();
        check_val("t2_addr2", 64'(m_address), 64'h102);
        check_val("t2_wait2", 64'(s_waitrequest), 64'd1);
        tick();
        check_val("t2_done", 64'(m_read), 64'd0);
        for (int i = 0; i < 3; i++) begin
            m_readdatavalid = 1'b1;
            m_readdata = 64'h1111_2222_3333_4444 * 64'(i + 1);
            settle();
            check_val("t2_rvalid", 64'(s_readdatavalid), 64'd1);
            check_val("t2_rdata", s_readdata, 64'h1111_2222_3333_4444 * 64'(i + 1));
            tick();
        end
        m_readdatavalid = 1'b0;
        settle();
        check_val("t2_rvalid_off", 64'(s_readdatavalid), 64'd0);

        // 3: five burst-2 writes with responses withheld
        n0 = n_wrrsp;
        for (int i = 0; i < 4; i++) begin
            s_write = 1'b1; s_address = 16'h0200 + 16'(2 * i); s_burstcount = 4'd2;
            settle();
            check_val("t3_wait_first", 64'(s_waitrequest), 64'd0);
            tick();
            settle();
            check_val("t3_addr_second", 64'(m_address), 64'h201 + 64'(2 * i));
            tick();
        end
        s_address = 16'h0208;
        settle();
        check_val("t3_full_wait", 64'(s_waitrequest), 64'd1);
        check_val("t3_full_m_write", 64'(m_write), 64'd0);
        tick();
        m_writeresponsevalid = 1'b1;
        tick();
        check_val("t3_still_full", 64'(s_waitrequest), 64'd1);
        tick();
        m_writeresponsevalid = 1'b0;
        settle();
        check_val("t3_unstall_wait", 64'(s_waitrequest), 64'd0);
        check_val("t3_unstall_m_write", 64'(m_write), 64'd1);
        check_val("t3_unstall_addr", 64'(m_address), 64'h208);
        tick();
        settle();
        check_val("t3_last_addr", 64'(m_address), 64'h209);
        tick();
        s_write = 1'b0;
        m_writeresponsevalid = 1'b1;
        repeat (8) tick();
        m_writeresponsevalid = 1'b0;
        tick();
        tick();
        check_val("t3_wrrsp_total", 64'(n_wrrsp - n0), 64'd5);

        // 4: address wrap and burstcount 0
        for (int i = 0; i < 3; i++) begin
            s_write = 1'b1; s_address = (i == 0) ? 16'hFFFF : 16'h1234; s_burstcount = 4'd3;
            settle();
            check_val("t4_wrap_addr", 64'(m_address), (i == 0) ? 64'hFFFF : 64'(i - 1));
            tick();
        end
        s_write = 1'b0;
        m_writeresponsevalid = 1'b1;
        repeat (3) tick();
        m_writeresponsevalid = 1'b0;
        tick();
        s_read = 1'b1; s_address = 16'h0030; s_burstcount = 4'd0;
        settle();
        check_val("t4_bc0_m_read", 64'(m_read), 64'd1);
        check_val("t4_bc0_addr", 64'(m_address), 64'h30);
        tick();
        s_read = 1'b0;
        settle();
        check_val("t4_bc0_single", 64'(m_read), 64'd0);

        // 5: reset mid write burst
        for (int i = 0; i < 2; i++) begin
            s_write = 1'b1; s_address = 16'h0040; s_burstcount = 4'd4;
            tick();
        end
        rst = 1'b1;
        settle();
        check_val("t5_rst_m_write", 64'(m_write), 64'd0);
        check_val("t5_rst_wait", 64'(s_waitrequest), 64'd1);
        check_val("t5_rst_m_read", 64'(m_read), 64'd0);
        s_write = 1'b0;
        tick();
        check_val("t5_rst_wrrsp", 64'(s_writeresponsevalid), 64'd0);
        rst = 1'b0;
        tick();
        s_write = 1'b1; s_address = 16'h0020; s_burstcount = 4'd1;
        settle();
        check_val("t5_m_write", 64'(m_write), 64'd1);
        check_val("t5_addr", 64'(m_address), 64'h20);
        check_val("t5_wait", 64'(s_waitrequest), 64'd0);
        tick();
        s_write = 1'b0;
        settle();
        check_val("t5_back_idle", 64'(s_waitrequest), 64'd1);
        n0 = n_wrrsp;
        m_writeresponsevalid = 1'b1;
        tick();
        m_writeresponsevalid = 1'b0;
        check_val("t5_wrrsp", 64'(s_writeresponsevalid), 64'd1);
        tick();
        tick();
        check_val("t5_wrrsp_count", 64'(n_wrrsp - n0), 64'd1);

        // stray response with nothing outstanding is dropped
        m_writeresponsevalid = 1'b1;
        tick();
        m_writeresponsevalid = 1'b0;
        check_val("stray_wrrsp", 64'(s_writeresponsevalid), 64'd0);
        tick();

        // 6: simultaneous write and read in IDLE
        s_write = 1'b1; s_read = 1'b1; s_address = 16'h0050; s_burstcount = 4'd1;
        settle();
        check_val("t6_m_write", 64'(m_write), 64'd1);
        check_val("t6_m_read", 64'(m_read), 64'd0);
        check_val("t6_addr", 64'(m_address), 64'h50);
        tick();
        s_write = 1'b0; s_read = 1'b0;
        m_writeresponsevalid = 1'b1;
        tick();
        m_writeresponsevalid = 1'b0;
        check_val("t6_wrrsp", 64'(s_writeresponsevalid), 64'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
